// File: rtl/ahb_uart_cmd_master.sv
// ahb_uart_cmd_master: FIFO-buffered byte-command AHB-Lite master for the AHB->APB UART subsystem.
// Optional completion counters (xfer_cnt/err_cnt) are built when AHB_UART_CMD_STATS_EN is defined.
module ahb_uart_cmd_master #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        HSELABPif,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZES,
  output logic [2:0]  HBURST,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic        HREADYout,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA
`ifdef AHB_UART_CMD_STATS_EN
  ,
  output logic [15:0] xfer_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef struct packed {
    logic        write;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          hold_q, hold_d;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          push, pop, complete, cpl_err;
  logic          unused_hrdata;

  assign unused_hrdata = ^HRDATA[31:8];
  assign cmd_ready     = (count_q != FULL_CNT);
  assign push          = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop         = 1'b0;
    complete    = 1'b0;
    cpl_err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: if (HREADYout) state_d = ST_DATA;
      ST_DATA: begin
        if (HREADYout) begin
          complete = 1'b1;
          cpl_err  = (HRESP == RESP_ERROR);
          state_d  = ST_IDLE;
        end else if (HRESP == RESP_ERROR) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (HREADYout) begin
          complete = 1'b1;
          cpl_err  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Response fields are zero outside the single strobe cycle.
    rsp_valid_d = complete;
    rsp_err_d   = cpl_err;
    rsp_rdata_d = (complete && !hold_q.write) ? HRDATA[7:0] : 8'h00;
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus outputs decode straight from state, so reset forces them idle without a clock.
  assign HSELABPif = (state_q == ST_ADDR);
  assign HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE    = (state_q == ST_ADDR) && hold_q.write;
  assign HADDR     = (state_q == ST_ADDR) ? (BASE_ADDR | {20'h0, hold_q.addr}) : 32'h0;
  assign HWDATA    = (state_q == ST_DATA || state_q == ST_ERR) ? {24'h0, hold_q.wdata} : 32'h0;
  assign HSIZES    = 3'b000;
  assign HBURST    = 3'b000;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (count_q != '0) || (state_q != ST_IDLE);

`ifdef AHB_UART_CMD_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (complete && xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
    if (complete && cpl_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      xfer_cnt_q <= 16'h0;
      err_cnt_q  <= 16'h0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_uart_cmd_master.sv
// Scoreboard bench for ahb_uart_cmd_master with a behavioural AHB slave.
// Stats checks are compiled in when AHB_UART_CMD_STATS_EN is defined.
module tb_ahb_uart_cmd_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [7:0]  rsp_rdata;
  logic        HSELABPif, HWRITE, HREADYout;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZES, HBURST;
  logic [31:0] HADDR, HWDATA, HRDATA;
`ifdef AHB_UART_CMD_STATS_EN
  logic [15:0] xfer_cnt, err_cnt;
`endif

  ahb_uart_cmd_master #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HSELABPif(HSELABPif), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZES(HSIZES),
    .HBURST(HBURST), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYout(HREADYout), .HRESP(HRESP), .HRDATA(HRDATA)
`ifdef AHB_UART_CMD_STATS_EN
    , .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [7:0]  d;
    int          e;   // 0 OKAY, 1 two-cycle ERROR, 2 one-cycle ERROR
    int          ws;  // data-phase wait states for OKAY responses
  } cmd_t;

  typedef struct {
    logic       err;
    logic [7:0] rd;
  } rsp_t;

  cmd_t exp_q[$];
  rsp_t rsp_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   n_addr_cyc = 0;
  int   n_rsp    = 0;
  int   last_acc_cyc = 0;
  int   last_rsp_cyc = 0;
  int   drv_err, drv_waits;
  logic stall;
  logic in_dp = 1'b0;
  int   dp_k  = 0;
  cmd_t cur;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Command/response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata, e: drv_err, ws: drv_waits});
          n_acc++;
          last_acc_cyc = cyc;
        end
        if (HTRANS == 2'b10) n_addr_cyc++;
        if (rsp_valid || rsp_q.size() != 0) begin
          check_val("rsp_valid", 32'(rsp_valid), 32'(rsp_q.size() != 0));
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            if (rsp_valid) begin
              n_rsp++;
              last_rsp_cyc = cyc;
              $display("rsp %0d: err=%0b rdata=0x%02h (exp err=%0b rdata=0x%02h)",
                       n_rsp, rsp_err, rsp_rdata, r.err, r.rd);
              check_val("rsp_err", 32'(rsp_err), 32'(r.err));
              check_val("rsp_rdata", 32'(rsp_rdata), 32'(r.rd));
            end
          end
        end
      end
    end
  end

  // Behavioural AHB slave; takes the expected command at address acceptance
  initial begin
    logic acc, done;
    HREADYout = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = 32'h0;
    forever begin
      @(negedge HCLK);
      acc  = HRESETn && (HTRANS == 2'b10) && HREADYout;
      done = HRESETn && in_dp && HREADYout;
      if (acc) begin
        check_val("hsel_addr", 32'(HSELABPif), 32'h1);
        if (exp_q.size() == 0) begin
          check_val("addr_unexpected", 32'h1, 32'h0);
          acc = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check_val("haddr", HADDR, BASE | {20'h0, cur.a});
          check_val("hwrite", 32'(HWRITE), 32'(cur.w));
        end
      end
      if (in_dp && HRESETn) begin
        check_val("htrans_dp", 32'(HTRANS), 32'h0);
        if (cur.w) check_val("hwdata", HWDATA, {24'h0, cur.d});
      end
      @(posedge HCLK); #1;
      if (!HRESETn) begin
        in_dp = 1'b0;
      end else begin
        if (done) begin
          rsp_q.push_back('{err: (cur.e != 0), rd: cur.w ? 8'h00 : (cur.a[7:0] ^ 8'h5A)});
          in_dp = 1'b0;
        end else if (in_dp) begin
          dp_k++;
        end
        if (acc) begin
          in_dp = 1'b1;
          dp_k  = 0;
        end
      end
      if (in_dp) begin
        case (cur.e)
          1:       begin HREADYout = (dp_k >= 1); HRESP = 2'b01; end
          2:       begin HREADYout = 1'b1;        HRESP = 2'b01; end
          default: begin HREADYout = (dp_k >= cur.ws); HRESP = 2'b00; end
        endcase
        HRDATA = HREADYout ? {24'hC3A5F0, cur.a[7:0] ^ 8'h5A} : 32'h0000_00FF;
      end else begin
        HREADYout = !stall;
        HRESP     = 2'b00;
        HRDATA    = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic send(input logic w, input logic [11:0] a, input logic [7:0] d,
                      input int e, input int ws);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    drv_err = e; drv_waits = ws;
    @(negedge HCLK);
    while (!cmd_ready && t < 200) begin
      @(negedge HCLK);
      t++;
    end
    check_val("send_timeout", 32'(t < 200), 32'h1);
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge HCLK);
    while ((busy || in_dp || exp_q.size() != 0 || rsp_q.size() != 0) && t < 500) begin
      @(negedge HCLK);
      t++;
    end
    check_val("drain_timeout", 32'(t < 500), 32'h1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    int a0, base_acc, t;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    drv_err = 0; drv_waits = 0; stall = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_htrans", 32'(HTRANS), 32'h0);
    check_val("rst_hsel", 32'(HSELABPif), 32'h0);
    check_val("rst_haddr", HADDR, 32'h0);
    check_val("rst_hwdata", HWDATA, 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check_val("hsize_hburst", {26'h0, HSIZES, HBURST}, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // 1: zero-wait write
    a0 = n_addr_cyc;
    send(1'b1, 12'h003, 8'h41, 0, 0);
    wait_idle();
    check_val("t1_addr_cycles", 32'(n_addr_cyc - a0), 32'h1);
    check_val("t1_latency", 32'(last_rsp_cyc - last_acc_cyc), 32'h4);

    // 2: read with three data-phase wait states
    send(1'b0, 12'h000, 8'h00, 0, 3);
    wait_idle();

    // 3: fill the FIFO while the slave stalls the address phase
    stall = 1'b1;
    base_acc = n_acc;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1; cmd_write = i[0]; cmd_addr = 12'h100 + 12'(i);
      cmd_wdata = 8'(i * 7 + 1); drv_err = 0; drv_waits = i % 2;
      @(posedge HCLK); #1;
    end
    cmd_valid = 1'b0;
    check_val("t3_accepts", 32'(n_acc - base_acc), 32'h5);
    check_val("t3_cmd_ready", 32'(cmd_ready), 32'h0);
    check_val("t3_busy", 32'(busy), 32'h1);
    stall = 1'b0;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge HCLK);
      t++;
    end
    check_val("t3_ready_back", 32'(cmd_ready), 32'h1);
    @(posedge HCLK); #1;
    wait_idle();

    // 4: two-cycle error, then OKAY; one-cycle error, then OKAY read
    send(1'b1, 12'h010, 8'hE7, 1, 0);
    send(1'b0, 12'h011, 8'h00, 0, 1);
    send(1'b1, 12'h012, 8'h3C, 2, 0);
    send(1'b0, 12'h0FF, 8'h00, 0, 0);
    wait_idle();

    // mixed back-to-back traffic
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
           8'($urandom_range(0, 255)), 0, int'($urandom_range(0, 2)));
    end
    wait_idle();

    // 5: reset during a long data phase with two commands queued
    send(1'b1, 12'h020, 8'h99, 0, 60);
    send(1'b0, 12'h021, 8'h00, 0, 0);
    send(1'b1, 12'h022, 8'h77, 0, 0);
    t = 0;
    while (!in_dp && t < 50) begin
      @(negedge HCLK);
      t++;
    end
    check_val("t5_in_data", 32'(in_dp), 32'h1);
    check_val("t5_busy_before", 32'(busy), 32'h1);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check_val("t5_htrans", 32'(HTRANS), 32'h0);
    check_val("t5_hwdata", HWDATA, 32'h0);
    check_val("t5_busy", 32'(busy), 32'h0);
    check_val("t5_cmd_ready", 32'(cmd_ready), 32'h1);
    check_val("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    exp_q.delete();
    rsp_q.delete();
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    a0 = n_rsp;
    repeat (12) @(posedge HCLK);
    #1;
    check_val("t5_no_rsp", 32'(n_rsp - a0), 32'h0);
    check_val("t5_busy_after", 32'(busy), 32'h0);

`ifdef AHB_UART_CMD_STATS_EN
    // 6: counters after reset
    check_val("t6_xfer_rst", 32'(xfer_cnt), 32'h0);
    send(1'b1, 12'h030, 8'h11, 0, 0);
    send(1'b0, 12'h031, 8'h00, 0, 1);
    send(1'b1, 12'h032, 8'h22, 1, 0);
    send(1'b0, 12'h033, 8'h00, 0, 0);
    wait_idle();
    check_val("t6_xfer_cnt", 32'(xfer_cnt), 32'h4);
    check_val("t6_err_cnt", 32'(err_cnt), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_uart_cmd_master.md
Name: ahb_uart_cmd_master

Overview:
AHB-Lite single-transfer master that sits directly upstream of the AHB-to-APB UART subsystem and drives its AHB slave port. Accepts byte-wide UART register commands (read/write, 12-bit offset) through a valid/ready interface and buffers them in a command FIFO. Issues each command as one non-pipelined NONSEQ SINGLE byte transfer and returns read data and error status on a response strobe.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
BASE_ADDR, 32'h0000_0000, OR-ed with the 12-bit offset to form HADDR.

Ports:
HCLK  in  1  clock, rising edge.
HRESETn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO not full.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  12  UART register offset.
cmd_wdata  in  8  write byte.
rsp_valid  out  1  one-cycle pulse: transfer completed.
rsp_rdata  out  8  HRDATA[7:0] on reads; 0 on writes.
rsp_err  out  1  qualified by rsp_valid: slave returned ERROR.
busy  out  1  FIFO non-empty or state != IDLE.
HSELABPif  out  1  slave select, address phase only.
HTRANS  out  2  2'b10 NONSEQ in ADDR, else 2'b00 IDLE.
HWRITE  out  1  transfer direction.
HSIZES  out  3  constant 3'b000 (byte).
HBURST  out  3  constant 3'b000 (SINGLE).
HADDR  out  32  BASE_ADDR | cmd_addr.
HWDATA  out  32  {24'b0, wdata}, valid in data phase.
HREADYout  in  1  slave ready.
HRESP  in  2  2'b00 OKAY, 2'b01 ERROR.
HRDATA  in  32  read data.

Behaviour:
- Reset (async, HRESETn=0): state IDLE; FIFO empty; HTRANS=00, HSELABPif=0, HWRITE=0, HADDR=0, HWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; busy=0; cmd_ready=1 (combinational from FIFO count). Reset mid-transfer drops the in-flight command and buffered commands; no rsp_valid is produced.
- FIFO push: occurs when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH). Push and pop in the same cycle are legal; count is unchanged.
- FSM:
  - IDLE: if the FIFO is non-empty, pop into the holding register and go to ADDR.
  - ADDR: drive HSELABPif=1, HTRANS=10, HADDR, HWRITE from the holding register. If HREADYout=1, go to DATA; otherwise hold all address-phase outputs unchanged.
  - DATA: HTRANS=00, HSELABPif=0; HWDATA is held for the whole phase.
    - HREADYout=1 and HRESP=00: complete OK.
    - HRESP=01 and HREADYout=0: go to ERR.
    - HRESP=01 and HREADYout=1: complete with error.
  - ERR: hold; complete with error on the first cycle where HREADYout=1.
- Completion: the cycle after completion, rsp_valid=1 for exactly one cycle. rsp_rdata is HRDATA[7:0] sampled on the completing edge for reads, 0 for writes. rsp_err is 1 only for error completion. FSM returns to IDLE.
- Responses have no backpressure.
- Minimum latency, zero wait states: push at edge N, pop at N+1, ADDR cycle N+1..N+2, DATA N+2..N+3, rsp_valid high N+3..N+4. A back-to-back transfer costs 3 cycles.
- Only one transfer is ever outstanding, so HTRANS is never NONSEQ during a data phase.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Optional Feature:
Macro AHB_UART_CMD_STATS_EN.
- Defined: adds output ports xfer_cnt[15:0] and err_cnt[15:0]. xfer_cnt increments on every completion. err_cnt increments on every error completion. Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Write: push write addr 0x003 data 0x41, slave zero-wait -> one cycle of HTRANS=10, HWRITE=1, HADDR=0x003; next cycle HWDATA=0x00000041; rsp_valid pulses with rsp_err=0, rsp_rdata=0x00.
2. Read: push read addr 0x000, slave holds HREADYout=0 for 3 data-phase cycles then HRDATA=0x0000005A -> rsp_valid one cycle after HREADYout rises, rsp_rdata=0x5A.
3. Full: DEPTH=4, HREADYout held 0, cmd_valid held 1 -> exactly 5 commands accepted, cmd_ready=0 thereafter. Release HREADYout -> 5 transfers in push order, cmd_ready reasserts after the first pop.
4. Error: slave returns HRESP=01/HREADYout=0 then HRESP=01/HREADYout=1 -> single rsp_valid with rsp_err=1; the following queued command completes OKAY.
5. Reset: assert HRESETn=0 during the DATA state with 2 commands queued -> immediately HTRANS=00, busy=0, cmd_ready=1; no rsp_valid after release.
6. Stats (macro defined): 3 OKAY + 1 ERROR transfers -> xfer_cnt=4, err_cnt=1.
